// File: rtl/reg_pipeline_pkg.sv
// Shared defaults and the occupancy-width helper for reg_pipeline.
package reg_pipeline_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_DEPTH     = 4;
    localparam int DEF_RESET_VAL = 0;

    function automatic int occ_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_pipeline_stage.sv
// One pipeline stage: valid flag, data register and local ready term.
module reg_pipeline_stage
    import reg_pipeline_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             down_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic ready;
    logic take;

    assign ready = ~valid | down_ready;
    // Flush blocks every load so no register toggles during the clear.
    assign take  = up_valid & ready & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= RESET_VAL;
        end else if (flush) begin
            valid <= 1'b0;
        end else begin
            valid <= take | (valid & ~down_ready);
            if (take) data <= up_data;
        end
    end

endmodule

// File: rtl/reg_pipeline.sv
// Bubble-collapsing valid/ready register pipeline of DEPTH stages.
// Define REG_PIPELINE_COUNT_EN to add the registered occupancy output.
module reg_pipeline
    import reg_pipeline_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               DEPTH     = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef REG_PIPELINE_COUNT_EN
    ,
    output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

    logic [DEPTH-1:0]            vld;
    logic [DEPTH-1:0][WIDTH-1:0] dat;
    logic [DEPTH-1:0]            down_rdy;
    logic                        head_rdy;

    // Ready ripples back from the output; a stage is ready if it or any later stage has room.
    always_comb begin : ready_chain
        logic acc;
        down_rdy = '0;
        acc      = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            down_rdy[i] = acc;
            acc         = ~vld[i] | acc;
        end
        head_rdy = acc;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_v;
        logic [WIDTH-1:0] up_d;

        if (i == 0) begin : g_head
            assign up_v = in_valid;
            assign up_d = in_data;
        end else begin : g_body
            assign up_v = vld[i-1];
            assign up_d = dat[i-1];
        end

        reg_pipeline_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .up_valid   (up_v),
            .up_data    (up_d),
            .down_ready (down_rdy[i]),
            .valid      (vld[i]),
            .data       (dat[i])
        );
    end

    assign in_ready  = head_rdy;
    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];

`ifdef REG_PIPELINE_COUNT_EN
    localparam int OW = occ_width(DEPTH);

    logic [OW-1:0] cnt;
    logic          acc_in;
    logic          acc_out;

    assign acc_in  = in_valid & head_rdy & ~flush;
    assign acc_out = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            cnt <= '0;
        end else if (acc_in && !acc_out) begin
            cnt <= cnt + OW'(1);
        end else if (!acc_in && acc_out) begin
            cnt <= cnt - OW'(1);
        end
    end

    assign occupancy = cnt;
`endif

endmodule

// File: tb/tb_reg_pipeline.sv
// Bench for reg_pipeline: directed table, corner sequences and a randomized model check.
module tb_reg_pipeline;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst, a_flush, a_iv, a_ir, a_ov, a_or;
    logic [7:0] a_id, a_od;
    logic       b_rst, b_flush, b_iv, b_ir, b_ov, b_or;
    logic [7:0] b_id, b_od;
`ifdef REG_PIPELINE_COUNT_EN
    logic [2:0] a_occ;
    logic [0:0] b_occ;
`endif

    reg_pipeline #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h3C)) dut_a (
        .clk(clk), .rst(a_rst), .flush(a_flush),
        .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
        .out_valid(a_ov), .out_ready(a_or), .out_data(a_od)
`ifdef REG_PIPELINE_COUNT_EN
        , .occupancy(a_occ)
`endif
    );

    reg_pipeline #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) dut_b (
        .clk(clk), .rst(b_rst), .flush(b_flush),
        .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
        .out_valid(b_ov), .out_ready(b_or), .out_data(b_od)
`ifdef REG_PIPELINE_COUNT_EN
        , .occupancy(b_occ)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_a(input logic r, input logic f, input logic iv, input logic [7:0] d, input logic o);
        a_rst = r; a_flush = f; a_iv = iv; a_id = d; a_or = o;
    endtask

    task automatic set_b(input logic r, input logic f, input logic iv, input logic [7:0] d, input logic o);
        b_rst = r; b_flush = f; b_iv = iv; b_id = d; b_or = o;
    endtask

    task automatic reset_a();
        set_a(1, 0, 0, 8'h00, 0);
        tick();
        set_a(0, 0, 0, 8'h00, 0);
    endtask

    // Reference model: list of entries (oldest first) tagged with their stage position.
    int         m_cnt [2];
    logic [7:0] m_dat [2][4];
    int         m_pos [2][4];
    logic [7:0] m_od  [2];

    function automatic logic m_ov(input int m, input int depth);
        return (m_cnt[m] > 0) && (m_pos[m][0] == depth - 1);
    endfunction

    task automatic model_step(input int m, input int depth, input logic rst, input logic flush,
                              input logic iv, input logic [7:0] id, input logic ordy,
                              input logic [7:0] rv);
        logic ir;
        int   lim;
        int   np;
        ir = (m_cnt[m] < depth) || ordy;
        if (rst) begin
            m_cnt[m] = 0;
            m_od[m]  = rv;
            return;
        end
        if (flush) begin
            m_cnt[m] = 0;
            return;
        end
        if (m_ov(m, depth) && ordy) begin
            for (int k = 0; k < m_cnt[m] - 1; k++) begin
                m_dat[m][k] = m_dat[m][k+1];
                m_pos[m][k] = m_pos[m][k+1];
            end
            m_cnt[m]--;
        end
        lim = depth - 1;
        for (int k = 0; k < m_cnt[m]; k++) begin
            np = (m_pos[m][k] + 1 > lim) ? lim : m_pos[m][k] + 1;
            if (np == depth - 1 && m_pos[m][k] != depth - 1) m_od[m] = m_dat[m][k];
            m_pos[m][k] = np;
            lim = np - 1;
        end
        if (iv && ir) begin
            m_dat[m][m_cnt[m]] = id;
            m_pos[m][m_cnt[m]] = 0;
            if (depth == 1) m_od[m] = id;
            m_cnt[m]++;
        end
    endtask

    typedef struct {
        logic       rst, flush, iv;
        logic [7:0] id;
        logic       ordy;
        logic       ir, ov;
        logic [7:0] od;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h3C};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h3C};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h3C};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 8'h3C};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 8'h11};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h11};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h44};

        set_a(1, 0, 0, 8'h00, 0);
        set_b(1, 0, 0, 8'h00, 0);
        @(negedge clk);
        tick();
`ifdef REG_PIPELINE_COUNT_EN
        chk("reset_occ", a_occ, 0);
`endif
        set_b(0, 0, 0, 8'h00, 0);

        // Directed table: fill while stalled, then drain
        for (int i = 0; i < 10; i++) begin
            set_a(tbl[i].rst, tbl[i].flush, tbl[i].iv, tbl[i].id, tbl[i].ordy);
            tick();
            chk($sformatf("tbl%0d_in_ready", i), a_ir, tbl[i].ir);
            chk($sformatf("tbl%0d_out_valid", i), a_ov, tbl[i].ov);
            chk($sformatf("tbl%0d_out_data", i), a_od, tbl[i].od);
        end

        // Stall fill: exactly four accepts, ready returns combinationally with out_ready
        reset_a();
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            set_a(0, 0, 1, 8'(k + 1), 0);
            #1;
            if (a_ir) acc++;
            tick();
        end
        chk("stall_accepts", acc, 4);
        chk("stall_in_ready", a_ir, 0);
        chk("stall_out_data", a_od, 8'h01);
`ifdef REG_PIPELINE_COUNT_EN
        chk("stall_occ", a_occ, 4);
`endif
        a_iv = 0; a_or = 1;
        #1;
        chk("stall_ready_same_cycle", a_ir, 1);
        for (int k = 2; k <= 4; k++) begin
            tick();
            chk($sformatf("stall_drain%0d", k), a_od, k);
        end
        tick();
        chk("stall_drained_valid", a_ov, 0);

        // Stream: latency 4, no gaps
        reset_a();
        for (int e = 1; e <= 22; e++) begin
            set_a(0, 0, (e <= 16), 8'(e), 1);
            tick();
            chk($sformatf("stream_valid_e%0d", e), a_ov, (e >= 4 && e <= 19));
            if (e >= 4 && e <= 19) chk($sformatf("stream_data_e%0d", e), a_od, e - 3);
        end

        // Bubble collapse
        reset_a();
        set_a(0, 0, 1, 8'hAA, 0); tick();
        set_a(0, 0, 0, 8'h00, 0); tick(); tick();
        set_a(0, 0, 1, 8'hBB, 0); tick();
        set_a(0, 0, 0, 8'h00, 0); tick(); tick();
        chk("bubble_valid", a_ov, 1);
        chk("bubble_head", a_od, 8'hAA);
        chk("bubble_in_ready", a_ir, 1);
`ifdef REG_PIPELINE_COUNT_EN
        chk("bubble_occ", a_occ, 2);
`endif
        set_a(0, 0, 0, 8'h00, 1); tick();
        chk("bubble_second", a_od, 8'hBB);
        chk("bubble_second_valid", a_ov, 1);
        tick();
        chk("bubble_empty", a_ov, 0);

        // Flush with a simultaneous push
        reset_a();
        for (int k = 0; k < 3; k++) begin
            set_a(0, 0, 1, 8'(8'h11 * (k + 1)), 0);
            tick();
        end
        set_a(0, 1, 1, 8'h55, 0);
        tick();
        chk("flush_valid", a_ov, 0);
        chk("flush_data_kept", a_od, 8'h3C);
`ifdef REG_PIPELINE_COUNT_EN
        chk("flush_occ", a_occ, 0);
`endif
        acc = 0;
        set_a(0, 0, 0, 8'h00, 1);
        for (int k = 0; k < 6; k++) begin
            tick();
            if (a_ov) acc++;
        end
        chk("flush_nothing_emerges", acc, 0);

        // Reset mid-stream
        reset_a();
        for (int k = 0; k < 4; k++) begin
            set_a(0, 0, 1, 8'(8'h60 + k), 0);
            tick();
        end
        chk("midrst_full", a_ov, 1);
        set_a(1, 0, 1, 8'h77, 0);
        tick();
        chk("midrst_valid", a_ov, 0);
        chk("midrst_data", a_od, 8'h3C);
        chk("midrst_in_ready", a_ir, 1);
`ifdef REG_PIPELINE_COUNT_EN
        chk("midrst_occ", a_occ, 0);
`endif
        set_a(0, 0, 0, 8'h00, 0);

        // DEPTH=1: one word per cycle, latency 1
        for (int e = 1; e <= 8; e++) begin
            set_b(0, 0, 1, 8'(e * 5), 1);
            #1;
            chk($sformatf("d1_in_ready_e%0d", e), b_ir, 1);
            tick();
            chk($sformatf("d1_valid_e%0d", e), b_ov, 1);
            chk($sformatf("d1_data_e%0d", e), b_od, e * 5);
        end
        set_b(0, 0, 1, 8'h99, 0);
        #1;
        chk("d1_full_stall", b_ir, 0);
        tick();
        chk("d1_held", b_od, 8'd40);

        // Randomized run against the reference model
        set_a(1, 0, 0, 8'h00, 0);
        set_b(1, 0, 0, 8'h00, 0);
        @(posedge clk);
        model_step(0, 4, 1, 0, 0, 8'h00, 0, 8'h3C);
        model_step(1, 1, 1, 0, 0, 8'h00, 0, 8'h00);
        @(negedge clk);
        for (int c = 0; c < 2000; c++) begin
            set_a(($urandom % 64) == 0, ($urandom % 16) == 0, ($urandom % 4) != 0,
                  8'($urandom), ($urandom % 3) != 0);
            set_b(($urandom % 64) == 0, ($urandom % 16) == 0, ($urandom % 4) != 0,
                  8'($urandom), ($urandom % 2) != 0);
            #1;
            chk("rnd_a_in_ready", a_ir, (m_cnt[0] < 4) || a_or);
            chk("rnd_a_out_valid", a_ov, m_ov(0, 4));
            chk("rnd_a_out_data", a_od, m_od[0]);
            chk("rnd_b_in_ready", b_ir, (m_cnt[1] < 1) || b_or);
            chk("rnd_b_out_valid", b_ov, m_ov(1, 1));
            chk("rnd_b_out_data", b_od, m_od[1]);
`ifdef REG_PIPELINE_COUNT_EN
            chk("rnd_a_occ", a_occ, m_cnt[0]);
            chk("rnd_b_occ", b_occ, m_cnt[1]);
`endif
            @(posedge clk);
            model_step(0, 4, a_rst, a_flush, a_iv, a_id, a_or, 8'h3C);
            model_step(1, 1, b_rst, b_flush, b_iv, b_id, b_or, 8'h00);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_pipeline.md
REG_PIPELINE -- requirements
Module: reg_pipeline

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, number of register stages (>=1).
REQ-003 SHALL have parameter RESET_VAL, default 0, WIDTH-bit value loaded into every stage data register on reset.
REQ-004 SHALL have one clock and a synchronous, active-high reset:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- flush  input  1  synchronous clear of all stage valids.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  pipeline accepts in_data this cycle.
- in_data  input  WIDTH  upstream data.
- out_valid  output  1  last stage holds valid data.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  WIDTH  last-stage data register.
- occupancy  output  $clog2(DEPTH+1)  count of valid stages (present only with REG_PIPELINE_COUNT_EN).

Function
REQ-005 SHALL hold one valid bit v[i] and one WIDTH-bit data register d[i] per stage i=0..DEPTH-1; stage 0 is the input stage, stage DEPTH-1 drives out_valid/out_data directly from flops.
REQ-006 SHALL compute ready per stage combinationally: r[DEPTH-1] = ~v[DEPTH-1] | out_ready; r[i] = ~v[i] | r[i+1]; in_ready = r[0].
REQ-007 SHALL perform a transfer into stage i when its upstream valid (in_valid for i=0, v[i-1] otherwise) and r[i] are both 1; on transfer d[i] loads upstream data and v[i] is set.
REQ-008 SHALL clear v[i] when stage i's content moves downstream (out_valid & out_ready for the last stage) and no new data enters in the same cycle.
REQ-009 SHALL leave d[i] unchanged in every cycle without a transfer into stage i (no data toggling on empty or stalled stages).
REQ-010 SHALL give latency exactly DEPTH cycles from an accepted in_valid&in_ready to out_valid when never stalled, and sustain one transfer per cycle with out_ready held high.
REQ-011 SHALL collapse bubbles: an empty stage accepts data even while out_ready=0, so a stalled pipeline fills to DEPTH entries before in_ready drops.
REQ-012 SHALL preserve order and never drop or duplicate a transfer.
REQ-013 SHALL, on flush=1, clear all v[i] at the next edge, ignore in_valid that cycle (no acceptance counted), and leave d[i] unchanged; in_ready and out_valid remain as computed from current state during the flush cycle.
REQ-014 SHALL treat out_valid&out_ready with flush=1 as a completed output transfer (downstream consumed it).
REQ-015 SHALL behave for DEPTH=1 as a single register with in_ready = ~v[0] | out_ready.

Reset
REQ-016 SHALL, while rst=1 at a rising edge, set all v[i]=0 and d[i]=RESET_VAL; rst takes precedence over flush and any transfer.
REQ-017 SHALL present out_valid=0, out_data=RESET_VAL, occupancy=0 the cycle after reset; in_ready=1 then.
REQ-018 SHALL discard all in-flight data when reset is asserted mid-operation; no partial stage survives.

Configuration
REQ-019 SHALL, with macro REG_PIPELINE_COUNT_EN defined, provide occupancy as a registered count equal to popcount(v) after each edge: +1 on input acceptance, -1 on output transfer, unchanged if both, 0 on flush or reset.
REQ-020 SHALL, without REG_PIPELINE_COUNT_EN, omit the occupancy port and its counter entirely; all other behaviour identical.

Structure
REQ-021 SHALL place default WIDTH/DEPTH/RESET_VAL constants and the occupancy width function in package reg_pipeline_pkg.
REQ-022 SHALL implement one stage (valid bit, data register, ready term) as sub-module reg_pipeline_stage, instantiated DEPTH times via generate.

Verification
REQ-023 Stream: WIDTH=8, DEPTH=4, out_ready=1, push 0x01..0x10 back-to-back -> out_data 0x01..0x10 in order, first out_valid 4 cycles after first accept, no gaps.
REQ-024 Stall fill: out_ready=0, in_valid=1 continuously -> exactly 4 accepts, in_ready=0 from 5th cycle, occupancy=4; raise out_ready -> in_ready=1 same cycle.
REQ-025 Bubble: push 0xAA, idle 2 cycles, push 0xBB with out_ready=0 -> both held, occupancy=2, then drained 0xAA then 0xBB.
REQ-026 Flush: 3 entries held, assert flush with in_valid=1 in_data=0x55 -> next cycle out_valid=0, occupancy=0, 0x55 never emerges.
REQ-027 Reset mid-stream: RESET_VAL=0x3C, rst during full pipeline -> next cycle out_valid=0, out_data=0x3C, in_ready=1.
REQ-028 DEPTH=1: simultaneous out transfer and new input each cycle -> one word per cycle, latency 1.
